reg_write_arbiter: RTL and testbench

Write-side front end for the 32x32 register file in the MIPS pipeline. It merges two result sources onto the register file's single write port: the in-order WB stage, and a long-latency multiply/divide unit (MDU) whose results arrive out of band. MDU results are buffered in a small FIFO. A scoreboard of pending destinations tells decode when to stall, and a forwarding path covers the cycle in which a registered write is still in flight to the register file.

---
 rtl/rf_pkg.sv | 14 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/reg_write_arbiter.sv | 115 +++++++++++
 tb/tb_reg_write_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the MIPS write-side front end.
// Carries the default widths, the write-port record and the hardwired-zero index.
package rf_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } rf_wr_t;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready push and a combinational head for same-cycle pop.
// The head is read asynchronously so the arbiter can load it straight into its output register.
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign push_ready = !full;
  assign do_push    = push_valid && !full;
  assign do_pop     = pop && !empty;
  assign pop_data   = mem[rd_ptr_reg];
  assign count      = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Merges WB-stage writes and buffered MDU results onto the single register-file write port,
// tracking pending MDU destinations for decode stalls and exposing the in-flight write for forwarding.
module reg_write_arbiter #(
  parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_we,
  input  logic [ADDR_WIDTH-1:0]   pipe_rd,
  input  logic [DATA_WIDTH-1:0]   pipe_data,
  input  logic                    mdu_valid,
  output logic                    mdu_ready,
  input  logic [ADDR_WIDTH-1:0]   mdu_rd,
  input  logic [DATA_WIDTH-1:0]   mdu_data,
  input  logic                    pend_set,
  input  logic [ADDR_WIDTH-1:0]   pend_reg,
  input  logic [ADDR_WIDTH-1:0]   rs,
  input  logic [ADDR_WIDTH-1:0]   rt,
  output logic                    stall,
  output logic                    fwd_rs_hit,
  output logic                    fwd_rt_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic                    reg_write,
  output logic [ADDR_WIDTH-1:0]   write_reg,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [$clog2(DEPTH):0]  q_count
);
  import rf_pkg::*;

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int FW   = ADDR_WIDTH + DATA_WIDTH;

  logic                  pipe_req;
  logic                  pop;
  logic                  fifo_ready;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FW-1:0]         head;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [NREG-1:0]       pending;
  logic                  reg_write_reg;
  logic [ADDR_WIDTH-1:0] write_reg_reg;
  logic [DATA_WIDTH-1:0] write_data_reg;

  // Writes to r0 are architecturally void, so they neither win the port nor enter the FIFO.
  assign pipe_req  = pipe_we && (pipe_rd != ADDR_WIDTH'(REG_ZERO));
  assign pop       = !pipe_req && !fifo_empty;
  assign mdu_ready = fifo_ready && !rst;
  assign fifo_push = mdu_valid && !rst && (mdu_rd != ADDR_WIDTH'(REG_ZERO));
  assign head_rd   = head[FW-1:DATA_WIDTH];
  assign head_data = head[DATA_WIDTH-1:0];

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (fifo_push),
    .push_ready (fifo_ready),
    .push_data  ({mdu_rd, mdu_data}),
    .pop        (pop),
    .pop_data   (head),
    .count      (q_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_reg  <= 1'b0;
      write_reg_reg  <= '0;
      write_data_reg <= '0;
    end else if (pipe_req) begin
      reg_write_reg  <= 1'b1;
      write_reg_reg  <= pipe_rd;
      write_data_reg <= pipe_data;
    end else if (pop) begin
      reg_write_reg  <= 1'b1;
      write_reg_reg  <= head_rd;
      write_data_reg <= head_data;
    end else begin
      reg_write_reg  <= 1'b0;
    end
  end

  assign pending[0] = 1'b0;

  // A fresh issue to the same register must survive the retirement of the older result.
  for (genvar gi = 1; gi < NREG; gi++) begin : g_pend
    logic bit_reg;
    logic set_hit;
    logic clr_hit;
    assign set_hit    = pend_set && (pend_reg == ADDR_WIDTH'(gi));
    assign clr_hit    = pop && (head_rd == ADDR_WIDTH'(gi));
    assign pending[gi] = bit_reg;
    always_ff @(posedge clk) begin
      if (rst)          bit_reg <= 1'b0;
      else if (set_hit) bit_reg <= 1'b1;
      else if (clr_hit) bit_reg <= 1'b0;
    end
  end

  assign stall      = pending[rs] | pending[rt];
  assign fwd_rs_hit = reg_write_reg && (write_reg_reg == rs) && (rs != ADDR_WIDTH'(REG_ZERO));
  assign fwd_rt_hit = reg_write_reg && (write_reg_reg == rt) && (rt != ADDR_WIDTH'(REG_ZERO));
  assign fwd_data   = write_data_reg;
  assign reg_write  = reg_write_reg;
  assign write_reg  = write_reg_reg;
  assign write_data = write_data_reg;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed plus randomized bench for reg_write_arbiter against a queue-based model
// of the write port, MDU buffer and pending-destination set.
module tb_reg_write_arbiter;
  import rf_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        pend_set;
  logic [4:0]  pend_reg;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        stall;
  logic        fwd_rs_hit;
  logic        fwd_rt_hit;
  logic [31:0] fwd_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [2:0]  q_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  rf_wr_t      mq[$];
  bit          m_pend[32];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  reg_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .pend_set(pend_set), .pend_reg(pend_reg), .rs(rs), .rt(rt),
    .stall(stall), .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit), .fwd_data(fwd_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data), .q_count(q_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    pend_set = 0; pend_reg = 0;
  endtask

  // Advance one clock, apply the architectural rules to the model, then compare.
  task automatic tick();
    bit     req;
    bit     room;
    rf_wr_t e;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_we = 0; m_rd = 0; m_data = 0;
    end else begin
      req  = pipe_we && (pipe_rd != 0);
      room = (mq.size() < DEPTH);
      if (req) begin
        m_we = 1; m_rd = pipe_rd; m_data = pipe_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1; m_rd = e.rd; m_data = e.data;
        m_pend[e.rd] = 0;
      end else begin
        m_we = 0;
      end
      if (mdu_valid && room && mdu_rd != 0) begin
        e.we = 1; e.rd = mdu_rd; e.data = mdu_data;
        mq.push_back(e);
      end
      if (pend_set && pend_reg != 0) m_pend[pend_reg] = 1;
    end
    #1;
    chk("reg_write",  {31'd0, reg_write}, {31'd0, m_we});
    chk("write_reg",  {27'd0, write_reg}, {27'd0, m_rd});
    chk("write_data", write_data, m_data);
    chk("fwd_data",   fwd_data, m_data);
    chk("q_count",    {29'd0, q_count}, mq.size());
    chk("mdu_ready",  {31'd0, mdu_ready}, {31'd0, (mq.size() < DEPTH) && !rst});
    chk("stall",      {31'd0, stall}, {31'd0, m_pend[rs] | m_pend[rt]});
    chk("fwd_rs_hit", {31'd0, fwd_rs_hit}, {31'd0, m_we && m_rd == rs && rs != 0});
    chk("fwd_rt_hit", {31'd0, fwd_rt_hit}, {31'd0, m_we && m_rd == rt && rt != 0});
    $display("t=%0t rst=%0b pipe=%0b/r%0d mdu=%0b/r%0d rdy=%0b -> we=%0b r%0d=%08h q=%0d stall=%0b",
             $time, rst, pipe_we, pipe_rd, mdu_valid, mdu_rd, mdu_ready,
             reg_write, write_reg, write_data, q_count, stall);
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    mdu_valid = 1; mdu_rd = r; mdu_data = d;
  endtask

  initial begin
    idle();
    rs = 0; rt = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    tick();

    // Reset mid-drain
    push(5'd5, 32'hAAAA0001); pend_set = 1; pend_reg = 5'd5; rs = 5'd5; tick();
    pend_set = 0;
    push(5'd6, 32'hAAAA0002); tick();
    push(5'd7, 32'hAAAA0003); tick();
    idle(); tick();
    rst = 1; tick();
    rst = 0;
    for (int i = 0; i < 4; i++) tick();

    // Priority: WB writes go first, MDU result follows
    push(5'd9, 32'h12345678); pipe_we = 1; pipe_rd = 5'd3; pipe_data = 32'h1; tick();
    mdu_valid = 0; pipe_rd = 5'd4; pipe_data = 32'h2; tick();
    idle();
    for (int i = 0; i < 4; i++) tick();

    // Full FIFO under continuous WB traffic, then a fifth push that must bounce
    pipe_we = 1; pipe_rd = 5'd2; pipe_data = 32'h0000_0BAD;
    for (int i = 0; i < 5; i++) begin
      push(5'(11 + i), 32'hF000_0000 + i);
      tick();
    end
    idle();
    for (int i = 0; i < 6; i++) tick();

    // Scoreboard stall and forwarding on retirement
    rs = 5'd10; rt = 5'd1;
    pend_set = 1; pend_reg = 5'd10; tick();
    pend_set = 0; tick();
    push(5'd10, 32'h0000DEAD); tick();
    idle();
    for (int i = 0; i < 3; i++) tick();

    // Re-issue r10 in the cycle its older result pops
    pend_set = 1; pend_reg = 5'd10; tick();
    pend_set = 0; push(5'd10, 32'h0000BEEF); tick();
    idle(); pend_set = 1; pend_reg = 5'd10; tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    push(5'd10, 32'h0000CAFE); tick();
    idle(); tick(); tick();

    // Register 0 is never written nor queued
    rs = 5'd0; rt = 5'd0;
    pipe_we = 1; pipe_rd = 5'd0; pipe_data = 32'hFFFF_FFFF;
    push(5'd0, 32'hEEEE_EEEE); pend_set = 1; pend_reg = 5'd0; tick();
    idle(); tick(); tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(99) < 2);
      pipe_we   = ($urandom_range(99) < 40);
      pipe_rd   = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31));
      pipe_data = $urandom;
      mdu_valid = ($urandom_range(99) < 50);
      mdu_rd    = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31));
      mdu_data  = $urandom;
      pend_set  = ($urandom_range(99) < 25);
      pend_reg  = 5'($urandom_range(31));
      rs        = 5'($urandom_range(31));
      rt        = 5'($urandom_range(31));
      tick();
    end
    rst = 0; idle();
    for (int i = 0; i < 6; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
